// File: rtl/prot_wave_gen_if.sv
// Stream input and sample-buffer write port of the waveform generator.
// The slave modport is the generator's view; the master modport is the producer/buffer side.
interface prot_wave_gen_if #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_data;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/prot_wave_gen.sv
// Serializes stream words MSB first into the sample buffer, each bit held for
// 2*(samp_freq/data_freq) consecutive addresses, so the protocol parser can read them back.
module prot_wave_gen #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           samp_freq,
  input  logic [31:0]           data_freq,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  prot_wave_gen_if.slave        bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {StIdle, StCalc, StWait, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic                  start_q;
  logic                  err_q, err_d;
  logic [31:0]           divisor_q, divisor_d;
  logic [31:0]           div_quo_q, div_quo_d;
  logic [31:0]           div_rem_q, div_rem_d;
  logic [4:0]            div_cnt_q, div_cnt_d;
  logic [15:0]           bit_len_q, bit_len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  last_q, last_d;
  logic [15:0]           samp_cnt_q, samp_cnt_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;

  logic        start_edge;
  logic [32:0] rem_shift, rem_sub;
  logic        quo_bit;
  logic [31:0] quo_next;
  logic        ratio_bad;

  assign start_edge = start & ~start_q;
  assign busy       = (state_q != StIdle);
  assign err        = err_q;

  // Restoring divide step: dividend bits shift out of div_quo_q as quotient bits shift in.
  // A zero divisor always "fits", which makes the quotient all ones.
  assign rem_shift = {div_rem_q, div_quo_q[31]};
  assign rem_sub   = rem_shift - {1'b0, divisor_q};
  assign quo_bit   = (rem_shift >= {1'b0, divisor_q});
  assign quo_next  = {div_quo_q[30:0], quo_bit};
  assign ratio_bad = (quo_next == 32'd0) || (quo_next > 32'd32767);

  always_comb begin
    state_d     = state_q;
    err_d       = 1'b0;
    divisor_d   = divisor_q;
    div_quo_d   = div_quo_q;
    div_rem_d   = div_rem_q;
    div_cnt_d   = div_cnt_q;
    bit_len_d   = bit_len_q;
    addr_d      = addr_q;
    shreg_d     = shreg_q;
    last_d      = last_q;
    samp_cnt_d  = samp_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    bus.s_ready = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          divisor_d = data_freq;
          div_quo_d = samp_freq;
          div_rem_d = '0;
          div_cnt_d = '0;
          addr_d    = start_addr;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        div_quo_d = quo_next;
        div_rem_d = quo_bit ? rem_sub[31:0] : rem_shift[31:0];
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd31) begin
          if (ratio_bad) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            bit_len_d = {quo_next[14:0], 1'b0};
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          shreg_d    = bus.s_data;
          last_d     = bus.s_last;
          bit_cnt_d  = '0;
          samp_cnt_d = '0;
          state_d    = StShift;
        end
      end
      StShift: begin
        bus.wr_en   = 1'b1;
        bus.wr_data = shreg_q[DATA_WIDTH-1];
        bus.wr_addr = addr_q;
        addr_d      = addr_q + 1'b1;
        if (samp_cnt_q == bit_len_q - 16'd1) begin
          shreg_d    = shreg_q << 1;
          samp_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
            state_d = last_q ? StDone : StWait;
          end
        end else begin
          samp_cnt_d = samp_cnt_q + 16'd1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      divisor_q  <= '0;
      div_quo_q  <= '0;
      div_rem_q  <= '0;
      div_cnt_q  <= '0;
      bit_len_q  <= '0;
      addr_q     <= '0;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      err_q      <= err_d;
      divisor_q  <= divisor_d;
      div_quo_q  <= div_quo_d;
      div_rem_q  <= div_rem_d;
      div_cnt_q  <= div_cnt_d;
      bit_len_q  <= bit_len_d;
      addr_q     <= addr_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_prot_wave_gen.sv
// Bench for prot_wave_gen: directed and randomized operations checked against an
// address-formula model of the written waveform.
module tb_prot_wave_gen;
  localparam int unsigned DW   = 10;
  localparam int unsigned AW   = 10;
  localparam longint      AMOD = longint'(1) << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   samp_freq = '0;
  logic [31:0]   data_freq = '0;
  logic [AW-1:0] start_addr = '0;
  logic          busy, done, err;

  prot_wave_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  prot_wave_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .samp_freq  (samp_freq),
    .data_freq  (data_freq),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logs, sampled mid-cycle
  int   wr_cyc[$];
  int   wr_adr[$];
  bit   wr_dat[$];
  int   hs_log[$];
  int   ready_log[$];
  int   done_log[$];
  int   err_log[$];
  int   fall_log[$];
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_adr.push_back(int'(bus.wr_addr));
      wr_dat.push_back(bus.wr_data);
    end
    if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) hs_log.push_back(cyc);
    if (bus.s_ready === 1'b1) ready_log.push_back(cyc);
    if (done === 1'b1) done_log.push_back(cyc);
    if (err === 1'b1) err_log.push_back(cyc);
    if (busy_prev === 1'b1 && busy === 1'b0) fall_log.push_back(cyc);
    busy_prev <= busy;
  end

  // Operation description and expected waveform
  logic [DW-1:0] words[4];
  int            nw;
  logic [31:0]   sf, df;
  logic [AW-1:0] a0;
  bit            exp_err;
  int            exp_adr[$];
  bit            exp_dat[$];

  task automatic check(input string tag, input longint obs, input longint expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Bit k of word n covers A0 + (n*DW+k)*bit_len .. +bit_len-1, modulo the buffer size.
  task automatic build_expect();
    longint q, bl;
    exp_adr.delete();
    exp_dat.delete();
    q = (df == 0) ? longint'(32'hFFFF_FFFF) : longint'(sf) / longint'(df);
    exp_err = (q == 0) || (q > 32767);
    if (!exp_err) begin
      bl = 2 * q;
      for (int n = 0; n < nw; n++)
        for (int k = 0; k < DW; k++)
          for (longint j = 0; j < bl; j++) begin
            exp_adr.push_back(int'((longint'(a0) + (n * DW + k) * bl + j) % AMOD));
            exp_dat.push_back(words[n][DW-1-k]);
          end
    end
  endtask

  // mode 0: normal, 1: start held 500 cycles, 2: second start edge mid-SHIFT,
  // 3: one-cycle reset mid-SHIFT
  task automatic run_op(input int mode, input string name);
    int start_cyc, idx, k, bad, n_cmp;
    build_expect();
    @(posedge clk); #1;
    wr_cyc.delete(); wr_adr.delete(); wr_dat.delete(); hs_log.delete();
    ready_log.delete(); done_log.delete(); err_log.delete(); fall_log.delete();
    samp_freq  = sf;
    data_freq  = df;
    start_addr = a0;
    start      = 1'b1;
    start_cyc  = cyc;
    idx = 0;
    k   = 0;
    do begin
      @(posedge clk); #1;
      k++;
      // Latched at start; scrambling them afterwards must not matter
      samp_freq  = $urandom;
      data_freq  = $urandom;
      start_addr = AW'($urandom);
      if (mode != 1 && k == 3) start = 1'b0;
      if (mode == 2 && hs_log.size() > 0 && cyc == hs_log[0] + 6) start = 1'b1;
      if (mode == 3 && hs_log.size() > 0 && cyc == hs_log[0] + 10) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        check({name, " outputs after reset"},
              longint'({busy, done, err, bus.s_ready, bus.wr_en, bus.wr_data, bus.wr_addr}), 0);
        rst_n = 1'b1;
      end
      if (bus.s_ready === 1'b1 && idx < nw) begin
        bus.s_valid = 1'b1;
        bus.s_data  = words[idx];
        bus.s_last  = (idx == nw - 1);
        idx++;
      end else begin
        bus.s_valid = 1'($urandom);
        bus.s_data  = DW'($urandom);
        bus.s_last  = 1'($urandom);
      end
    end while (busy === 1'b1 && k < 5000);
    bus.s_valid = 1'b0;
    while (cyc - start_cyc < ((mode == 1) ? 500 : 0)) begin
      @(posedge clk); #1;
    end
    repeat (20) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({name, " idle at end"}, longint'(busy), 0);

    // Writes seen so far must match the model position by position
    bad = 0;
    n_cmp = (wr_adr.size() < exp_adr.size()) ? wr_adr.size() : exp_adr.size();
    for (int i = 0; i < n_cmp; i++)
      if (wr_adr[i] != exp_adr[i] || wr_dat[i] != exp_dat[i]) bad++;
    check({name, " addr/data errors"}, bad, 0);

    if (mode == 3) begin
      check({name, " no done"}, done_log.size(), 0);
      check({name, " no err"}, err_log.size(), 0);
    end else if (exp_err) begin
      check({name, " err pulses"}, err_log.size(), 1);
      if (err_log.size() > 0) check({name, " err latency"}, err_log[0] - start_cyc, 33);
      check({name, " wr_en count"}, wr_cyc.size(), 0);
      check({name, " s_ready count"}, ready_log.size(), 0);
      check({name, " done count"}, done_log.size(), 0);
    end else begin
      check({name, " write count"}, wr_cyc.size(), exp_adr.size());
      check({name, " handshakes"}, hs_log.size(), nw);
      check({name, " done count"}, done_log.size(), 1);
      check({name, " err count"}, err_log.size(), 0);
      if (wr_cyc.size() > 0 && hs_log.size() > 0) begin
        check({name, " first write latency"}, wr_cyc[0] - hs_log[0], 1);
        check({name, " write span"}, wr_cyc[wr_cyc.size()-1] - wr_cyc[0] + 1,
              exp_adr.size() + nw - 1);
      end
      if (done_log.size() > 0 && fall_log.size() > 0)
        check({name, " busy fall after done"}, fall_log[0] - done_log[0], 1);
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    start       = 1'b1;  // high through reset: must still launch exactly one op later
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs",
          longint'({busy, done, err, bus.s_ready, bus.wr_en, bus.wr_data, bus.wr_addr}), 0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);

    sf = 1000; df = 100; a0 = 5; nw = 1; words[0] = 10'b1000000001;
    run_op(0, "one_word");

    nw = 2; words[0] = 10'h3FF; words[1] = 10'h000;
    run_op(0, "two_words");

    sf = 4; df = 2; a0 = 10'd1020; nw = 1; words[0] = 10'h2AA;
    run_op(0, "wrap");

    sf = 1000; df = 0; a0 = 7;
    run_op(0, "div_zero");
    sf = 50; df = 100;
    run_op(0, "q_zero");
    sf = 32768; df = 1;
    run_op(0, "q_big");

    sf = 8; df = 2; a0 = 100; nw = 1; words[0] = 10'h1C5;
    run_op(1, "start_held");

    sf = 1000; df = 100; a0 = 300; nw = 1; words[0] = 10'h155;
    run_op(2, "second_edge");

    sf = 1000; df = 100; a0 = 40; nw = 2; words[0] = 10'h2F0; words[1] = 10'h0F1;
    run_op(3, "reset_mid");
    run_op(0, "after_reset");

    for (int r = 0; r < 10; r++) begin
      nw = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) words[i] = DW'($urandom);
      df = $urandom_range(1, 60);
      if (r % 5 == 4) sf = $urandom_range(0, df - 1);
      else            sf = $urandom_range(1, 4) * df + $urandom_range(0, df - 1);
      a0 = AW'($urandom);
      run_op(0, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prot_wave_gen.md
Name: prot_wave_gen

Overview:
- Transmit-side counterpart of the logic-analyzer protocol parser.
- Takes parallel DATA_WIDTH-bit words over a valid/ready stream and serializes each word MSB first as an oversampled 1-bit waveform.
- Writes that waveform into the sample buffer. Each bit fills 2*(samp_freq/data_freq) consecutive addresses.
- Used to preload known patterns, so the parser can recover them word-for-word in self-test and loopback.

Parameters:
- DATA_WIDTH, 10, bits per word; legal range 2..16.
- ADDR_WIDTH, 10, sample-buffer address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- samp_freq  in  32  sample rate; latched at start.
- data_freq  in  32  bit rate; latched at start.
- start  in  1  level; its rising edge launches an operation.
- start_addr  in  ADDR_WIDTH  first write address; latched at start.
- s_valid  in  1  input word valid.
- s_data  in  DATA_WIDTH  input word.
- s_last  in  1  marks the final word of the operation.
- s_ready  out  1  word accepted when s_valid && s_ready.
- wr_en  out  1  sample-buffer write strobe.
- wr_addr  out  ADDR_WIDTH  write address.
- wr_data  out  1  sample value.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at normal completion.
- err  out  1  one-cycle pulse on an illegal rate ratio.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address, counters and shift register 0. Reset has priority in every state and aborts an operation immediately with no done or err pulse.
- Start detect: start is registered; start_edge = start & ~start_q. The edge is honoured only in IDLE and ignored while busy. Holding start high produces one operation only.
- IDLE:
  - On start_edge, latch samp_freq, data_freq and start_addr (into the address register) and go to CALC.
- CALC:
  - Restoring divider computes q = samp_freq / data_freq, one quotient bit per cycle. CALC lasts exactly 32 cycles.
  - data_freq=0 yields q=32'hFFFFFFFF; no special case is needed.
  - If q==0 or q>32767: pulse err on the cycle after the last divide cycle, return to IDLE, and never assert wr_en.
  - Otherwise set bit_len = 2*q (16 bits) and go to WAIT.
- WAIT:
  - s_ready=1, and it is asserted only in this state.
  - On handshake, load s_data into the shift register, capture s_last and go to SHIFT. bit counter = 0, sample counter = 0.
- SHIFT:
  - Every cycle: wr_en=1, wr_data = shift-register MSB, wr_addr = address register; then address += 1.
  - When sample counter reaches bit_len-1, shift left by 1, clear the sample counter and increment the bit counter.
  - After DATA_WIDTH*bit_len writes: if the captured last flag is set, go to DONE, otherwise go to WAIT.
- DONE:
  - done=1 for one cycle, then IDLE.
- Latency:
  - The first wr_en is 1 cycle after the accepted handshake.
  - Each word takes DATA_WIDTH*bit_len consecutive write cycles, followed by 1 idle WAIT cycle before the next handshake is possible.
  - The WAIT gap never skips an address, so addresses are contiguous across words.
- Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently, with no flag.
- Parser compatibility:
  - Bit k of word n occupies addresses A0 + (n*DATA_WIDTH + k)*bit_len through A0 + (n*DATA_WIDTH + k + 1)*bit_len - 1, where A0 = start_addr.
  - The parser's mid-bit sample point, start + 2q(k+1) - 2, lies inside bit k.
- s_data and s_last are sampled only at the handshake. Changes while in SHIFT have no effect.
- s_valid in any state other than WAIT is ignored; s_ready stays 0.
- done and err are never asserted in the same cycle.

Test Plan:
- samp_freq=1000, data_freq=100, start_addr=5, one word 10'b1000000001 with s_last=1 -> 32 CALC cycles; then 200 writes at addresses 5..204; wr_data=1 at 5..24 and 185..204, 0 elsewhere; done pulses once; busy falls on the following cycle.
- Same rates, two words 10'h3FF then 10'h000 (last on the second) -> 400 contiguous writes, addresses 5..404; 1 at 5..204, 0 at 205..404; exactly one s_ready gap cycle between the words; a single done.
- start_addr=1020, samp_freq=4, data_freq=2 (bit_len=4), word 10'h2AA -> 40 writes; addresses 1020..1023 then 0..35; pattern alternates 1/0 every 4 samples starting with 1.
- data_freq=0, then separately samp_freq=50 with data_freq=100 -> err pulse exactly 33 cycles after start_edge; wr_en and s_ready never asserted; back in IDLE.
- start held high for 500 cycles, plus a second rising edge mid-SHIFT -> exactly one operation; the second edge is ignored.
- rst_n low for 1 cycle mid-SHIFT -> the next cycle shows all outputs 0 and state IDLE; no done; a fresh start then completes normally.
